// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed seven-segment display controller with per-digit register file
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int SEL_W       = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write,
   input  logic [SEL_W-1:0]      sel,
   input  logic [3:0]            num,
   input  logic                  dp_in,
   input  logic                  blank_in,
   input  logic                  clear,
   output logic [6:0]            segments,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] anode
);

   localparam int PW = $clog2(REFRESH_DIV);

   logic [PW-1:0]         prescale;
   logic [SEL_W-1:0]      idx;
   logic [3:0]            e_num [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] e_dp;
   logic [NUM_DIGITS-1:0] e_blank;
   logic [3:0]            cur_num;
   logic                  cur_dp;
   logic                  cur_blank;

   // active-low {g,f,e,d,c,b,a} pattern for a hex digit
   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      case (v)
         4'h0: hex_decode = 7'h40;
         4'h1: hex_decode = 7'h79;
         4'h2: hex_decode = 7'h24;
         4'h3: hex_decode = 7'h30;
         4'h4: hex_decode = 7'h19;
         4'h5: hex_decode = 7'h12;
         4'h6: hex_decode = 7'h02;
         4'h7: hex_decode = 7'h78;
         4'h8: hex_decode = 7'h00;
         4'h9: hex_decode = 7'h10;
         4'hA: hex_decode = 7'h08;
         4'hB: hex_decode = 7'h03;
         4'hC: hex_decode = 7'h46;
         4'hD: hex_decode = 7'h21;
         4'hE: hex_decode = 7'h06;
         default: hex_decode = 7'h0E;
      endcase
   endfunction

   // prescaler and digit index: index steps on each prescaler wrap, no idle slots
   always_ff @(posedge clk) begin
      if (!reset) begin
         prescale <= '0;
         idx      <= '0;
      end else if (prescale == PW'(REFRESH_DIV - 1)) begin
         prescale <= '0;
         idx      <= (idx == SEL_W'(NUM_DIGITS - 1)) ? '0 : idx + SEL_W'(1);
      end else begin
         prescale <= prescale + PW'(1);
      end
   end

   // register file: clear first, then the write so the addressed entry keeps the new value;
   // selects with no matching entry fall through and change nothing
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_DIGITS; i++) e_num[i] <= 4'h0;
         e_dp    <= '0;
         e_blank <= '1;
      end else begin
         if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) e_num[i] <= 4'h0;
            e_dp    <= '0;
            e_blank <= '1;
         end
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (write && (sel == SEL_W'(i))) begin
               e_num[i]   <= num;
               e_dp[i]    <= dp_in;
               e_blank[i] <= blank_in;
            end
         end
      end
   end

   // select the entry currently being scanned
   always_comb begin
      cur_num   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == SEL_W'(i)) begin
            cur_num   = e_num[i];
            cur_dp    = e_dp[i];
            cur_blank = e_blank[i];
         end
      end
   end

   // registered output stage driving the shared cathodes and one-hot anodes
   always_ff @(posedge clk) begin
      if (!reset) begin
         anode    <= '1;
         segments <= 7'h7F;
         dp       <= 1'b1;
      end else begin
         anode <= ~(NUM_DIGITS'(1) << idx);
         if (cur_blank) begin
            segments <= 7'h7F;
            dp       <= 1'b1;
         end else begin
            segments <= hex_decode(cur_num);
            dp       <= ~cur_dp;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl (8-digit and 6-digit instances)
module tb_seg7_scan_ctrl;

   localparam int RD = 4;

   logic       clk = 1'b0;
   logic       reset, write, clear, dp_in, blank_in;
   logic [2:0] sel;
   logic [3:0] num;
   logic [6:0] seg8, seg6;
   logic       dp8, dp6;
   logic [7:0] an8;
   logic [5:0] an6;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(RD)) u8 (
      .clk(clk), .reset(reset), .write(write), .sel(sel), .num(num), .dp_in(dp_in),
      .blank_in(blank_in), .clear(clear), .segments(seg8), .dp(dp8), .anode(an8));

   seg7_scan_ctrl #(.NUM_DIGITS(6), .REFRESH_DIV(RD)) u6 (
      .clk(clk), .reset(reset), .write(write), .sel(sel), .num(num), .dp_in(dp_in),
      .blank_in(blank_in), .clear(clear), .segments(seg6), .dp(dp6), .anode(an6));

   typedef struct {
      logic [2:0] sel;
      logic [3:0] num;
      logic [6:0] exp_seg;
   } vec_t;

   vec_t       tbl [8];
   logic [6:0] hex_tab [16];
   int         nd [2];
   bit         m_blank [2][16];
   bit         m_dp [2][16];
   logic [3:0] m_num [2][16];
   int         tick;
   int         checks   = 0;
   int         failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16; i++) begin
            m_blank[k][i] = 1'b1;
            m_dp[k][i]    = 1'b0;
            m_num[k][i]   = 4'h0;
         end
      tick = 0;
   endtask

   // one clock: predict outputs from the state before the edge, then advance the model
   task automatic cyc();
      logic [31:0] ea [2];
      logic [31:0] es [2];
      logic [31:0] ed [2];
      int          d;
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            ea[k] = (32'd1 << nd[k]) - 1;
            es[k] = 32'h7F;
            ed[k] = 32'd1;
         end else begin
            d     = (tick / RD) % nd[k];
            ea[k] = ((32'd1 << nd[k]) - 1) & ~(32'd1 << d);
            es[k] = m_blank[k][d] ? 32'h7F : 32'(hex_tab[m_num[k][d]]);
            ed[k] = m_blank[k][d] ? 32'd1 : 32'(!m_dp[k][d]);
         end
      end
      @(posedge clk);
      if (!reset) begin
         model_reset();
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (clear)
               for (int i = 0; i < 16; i++) begin
                  m_blank[k][i] = 1'b1;
                  m_dp[k][i]    = 1'b0;
                  m_num[k][i]   = 4'h0;
               end
            if (write && int'(sel) < nd[k]) begin
               m_blank[k][sel] = blank_in;
               m_dp[k][sel]    = dp_in;
               m_num[k][sel]   = num;
            end
         end
         tick++;
      end
      #1;
      chk("anode8", 32'(an8), ea[0]);
      chk("seg8",   32'(seg8), es[0]);
      chk("dp8",    32'(dp8), ed[0]);
      chk("anode6", 32'(an6), ea[1]);
      chk("seg6",   32'(seg6), es[1]);
      chk("dp6",    32'(dp6), ed[1]);
   endtask

   task automatic wr(input logic [2:0] s, input logic [3:0] n, input logic d, input logic b);
      write = 1'b1; sel = s; num = n; dp_in = d; blank_in = b;
      cyc();
      write = 1'b0;
   endtask

   task automatic load_table();
      for (int j = 0; j < 8; j++) wr(tbl[j].sel, tbl[j].num, 1'b0, 1'b0);
   endtask

   task automatic align_frame();
      for (int i = 0; i < 64 && (tick % 32) != 0; i++) cyc();
      chk("align_frame", 32'(tick % 32), 32'd0);
   endtask

   initial begin
      logic       seen;
      logic [5:0] prev6;
      hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      nd = '{8, 6};
      tbl[0] = '{3'd7, 4'h2, 7'h24};
      tbl[1] = '{3'd6, 4'h0, 7'h40};
      tbl[2] = '{3'd5, 4'h2, 7'h24};
      tbl[3] = '{3'd4, 4'h2, 7'h24};
      tbl[4] = '{3'd3, 4'hE, 7'h06};
      tbl[5] = '{3'd2, 4'hE, 7'h06};
      tbl[6] = '{3'd1, 4'h1, 7'h79};
      tbl[7] = '{3'd0, 4'h3, 7'h30};
      model_reset();

      // reset held with a write pending
      reset = 1'b0; write = 1'b1; clear = 1'b0; sel = 3'd3; num = 4'h5; dp_in = 1'b1; blank_in = 1'b0;
      repeat (3) cyc();
      chk("rst_anode", 32'(an8), 32'hFF);
      chk("rst_seg", 32'(seg8), 32'h7F);
      chk("rst_dp", 32'(dp8), 32'd1);
      reset = 1'b1; write = 1'b0;
      cyc();
      chk("rel_anode", 32'(an8), 32'hFE);
      chk("rel_seg", 32'(seg8), 32'h7F);

      // load table, then two full frames
      load_table();
      align_frame();
      for (int c = 0; c < 64; c++) begin
         cyc();
         chk("frame_anode", 32'(an8), 32'(8'(~(8'd1 << ((c / RD) % 8)))));
         for (int j = 0; j < 8; j++)
            if (an8 == 8'(~(8'd1 << tbl[j].sel))) chk("frame_seg", 32'(seg8), 32'(tbl[j].exp_seg));
      end

      // decimal point, then blank on digit 2
      wr(3'd2, 4'h8, 1'b1, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc();
         if (an8 == 8'hFB) begin
            seen = 1'b1;
            chk("dp_seg", 32'(seg8), 32'h00);
            chk("dp_dp", 32'(dp8), 32'd0);
         end
      end
      chk("dp_seen", 32'(seen), 32'd1);
      wr(3'd2, 4'h8, 1'b1, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (an8 == 8'hFB) begin
            seen = 1'b1;
            chk("blank_seg", 32'(seg8), 32'h7F);
            chk("blank_dp", 32'(dp8), 32'd1);
         end
         if (an8 == 8'hF7) chk("neighbour_seg", 32'(seg8), 32'h06);
      end
      chk("blank_seen", 32'(seen), 32'd1);

      // out-of-range selects on the 6-digit instance
      wr(3'd6, 4'h9, 1'b0, 1'b0);
      wr(3'd7, 4'h9, 1'b0, 1'b0);
      prev6 = an6;
      for (int i = 0; i < 60; i++) begin
         cyc();
         chk("an6_legal", 32'(an6 inside {6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F}), 32'd1);
         if (an6 == 6'h3E && prev6 != 6'h3E) chk("an6_wrap", 32'(prev6), 32'h1F);
         prev6 = an6;
      end

      // clear and write on the same edge
      load_table();
      write = 1'b1; clear = 1'b1; sel = 3'd4; num = 4'hA; dp_in = 1'b0; blank_in = 1'b0;
      cyc();
      write = 1'b0; clear = 1'b0;
      for (int i = 0; i < 32; i++) begin
         cyc();
         chk("clrwr_seg", 32'(seg8), (an8 == 8'hEF) ? 32'h08 : 32'h7F);
      end

      // reset in the middle of digit 5's slot
      load_table();
      for (int i = 0; i < 64 && (tick % 32) != 22; i++) cyc();
      chk("mid_align", 32'(tick % 32), 32'd22);
      reset = 1'b0;
      cyc();
      chk("mid_rst_anode", 32'(an8), 32'hFF);
      reset = 1'b1;
      for (int i = 0; i < RD; i++) begin
         cyc();
         chk("restart_anode", 32'(an8), 32'hFE);
         chk("restart_seg", 32'(seg8), 32'h7F);
      end
      cyc();
      chk("restart_next", 32'(an8), 32'hFD);

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         reset    = ($urandom_range(0, 199) != 0);
         write    = ($urandom_range(0, 2) == 0);
         clear    = ($urandom_range(0, 40) == 0);
         sel      = 3'($urandom);
         num      = 4'($urandom);
         dp_in    = 1'($urandom);
         blank_in = ($urandom_range(0, 4) == 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller for the lab display boards. It holds a per-digit register file of hex value, decimal point and blank flag, loaded one digit at a time through a write/select port. A programmable prescaler time-division scans the digits onto a shared active-low cathode bus with one-hot active-low anodes. It generalises the fixed 8-digit display experiment with these additions:
- parametrised digit count and refresh rate;
- decimal point;
- per-digit blanking;
- global clear.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits/anodes; legal 2..16
- REFRESH_DIV, 100000, clk cycles each digit is driven; legal ≥ 2 (benches use 4)
- SEL_W, $clog2(NUM_DIGITS), select width (derived, not overridden)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- write  in  1  load entry[sel] on this edge
- sel  in  SEL_W  digit index to load; index 0 = rightmost digit = anode[0]
- num  in  4  hex value 0x0..0xF to load
- dp_in  in  1  decimal point to load, 1 = lit
- blank_in  in  1  blank flag to load, 1 = digit dark
- clear  in  1  set every entry blank
- segments  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal-point cathode, active-low
- anode  out  NUM_DIGITS  digit enables, one-hot active-low

## Operation
Register file: NUM_DIGITS entries, each {blank, dp, num}.
- Reset value of every entry: blank=1, dp=0, num=0.
- write=1 with sel < NUM_DIGITS: entry[sel] ← {blank_in, dp_in, num}.
- write=1 with sel ≥ NUM_DIGITS: ignored, no entry changes.
- clear=1: every entry gets blank=1, dp=0, num=0.
- clear and write on the same edge: clear applies to all entries, then the write is applied, so the addressed entry takes the written value.

Scanner:
- Prescaler counts 0..REFRESH_DIV-1, then wraps to 0.
- On the wrap edge, the digit index advances idx → (idx+1) mod NUM_DIGITS.
- Index wraps from NUM_DIGITS-1 to 0; there are no idle slots.

Output stage (registered):
- anode ← ~(1 << idx).
- If entry[idx].blank=1: segments ← 7'h7F and dp ← 1.
- Otherwise: segments ← hex_decode(num) and dp ← ~entry[idx].dp.

Hex decode, active-low: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex values).

Reset (reset=0 sampled on an edge):
- prescaler=0, idx=0, all entries reset.
- anode=all ones, segments=7'h7F, dp=1.
- Reset overrides write and clear.
- Reset mid-scan aborts the scan and restarts at digit 0.

## Timing
- Every output is a flop. Output at edge t+1 reflects idx and entries as they stand after edge t.
- First edge after reset release: anode=~1 (digit 0), blank pattern.
- Each digit is driven for exactly REFRESH_DIV consecutive cycles. A full frame is NUM_DIGITS×REFRESH_DIV cycles.
- Write-to-display latency: a write on edge k is visible on edge k+1 if idx = sel at that time. Otherwise it shows when the scan next reaches that digit.
- Exactly one anode is low in every non-reset cycle. All anodes are high only during reset and the cycle it is applied.
- Inputs may change every cycle. One write per cycle; there is no handshake.

## Test plan
- Reset: hold reset=0 for 3 cycles with write=1 asserted → anode=8'hFF, segments=7'h7F, dp=1, no entry loaded. Release → next edge anode=8'hFE, segments=7'h7F.
- Load and scan (NUM_DIGITS=8, REFRESH_DIV=4): write sel 7..0 = 2,0,2,2,E,E,1,3 with blank_in=0 → one frame shows:
  - anode FE/FD/FB/F7/EF/DF/BF/7F, 4 cycles each;
  - segments 30,79,06,06,24,24,40,24;
  - frame repeats after 32 cycles.
- Decimal point and blank: write sel=2, num=8, dp_in=1 → segments 00, dp=0 while anode=FB. Write sel=2, blank_in=1 → segments 7F, dp=1 on that slot; other digits unaffected.
- Out-of-range select (NUM_DIGITS=6, SEL_W=3): write sel=6 and sel=7 → no entry changes, anode cycles 6'h3E..6'h1F only, idx wraps 5→0.
- Clear plus write: load all digits, then on one edge clear=1, write=1, sel=4, num=A → only digit 4 shows 08, all others show 7F.
- Reset mid-operation: assert reset while idx=5 with prescaler mid-count → next edge anode all ones. After release, scanning restarts at digit 0 with a full 4-cycle slot and all digits blank.
